// File: rtl/trig_delay_pkg.sv
// Shared state type, register map helpers and control bit positions for trig_delay_gen.
package trig_delay_pkg;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

   localparam int ARM_BIT     = 0;
   localparam int OVR_CLR_BIT = 1;

   function automatic int delay_addr(input int ch);
      return 2 * ch;
   endfunction

   function automatic int width_addr(input int ch);
      return 2 * ch + 1;
   endfunction

   function automatic int frame_addr(input int num_ch);
      return 2 * num_ch;
   endfunction

   function automatic int ctrl_addr(input int num_ch);
      return 2 * num_ch + 1;
   endfunction

endpackage

// File: rtl/trig_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input followed by a registered
// single-cycle rising-edge pulse.
module trig_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic edge_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   last_q;
   logic                   edge_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         last_q <= 1'b0;
         edge_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
         last_q <= sync_q[SYNC_STAGES-1];
         edge_q <= sync_q[SYNC_STAGES-1] & ~last_q;
      end
   end

   assign edge_o = edge_q;

endmodule

// File: rtl/trig_delay_gen.sv
// Multi-channel trigger-to-pulse sequencer with shadowed timing registers.
// Optional macro RETRIGGER_EN: an armed trigger during a frame restarts it instead of flagging overrun.
module trig_delay_gen
   import trig_delay_pkg::*;
#(
   parameter  int NUM_CH      = 4,
   parameter  int CNT_W       = 16,
   parameter  int SYNC_STAGES = 2,
   localparam int AW          = $clog2(2 * NUM_CH + 2)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              trig_in,
   input  logic              cfg_we,
   input  logic [AW-1:0]     cfg_addr,
   input  logic [CNT_W-1:0]  cfg_wdata,
   output logic [NUM_CH-1:0] ch_out,
   output logic              busy,
   output logic              overrun,
   output logic [15:0]       trig_count
);

   logic                          trig_edge;
   logic [NUM_CH-1:0][CNT_W-1:0]  dly_sh_q, wid_sh_q, dly_act_q, wid_act_q;
   logic [CNT_W-1:0]              flen_sh_q, flen_act_q, last_cnt;
   logic [CNT_W-1:0]              cnt_q, cnt_d;
   logic [15:0]                   tcnt_q, tcnt_d;
   logic [NUM_CH-1:0]             ch_q, ch_d;
   logic                          arm_q, ovr_q, ovr_d;
   state_e                        state_q, state_d;
   logic                          edge_acc, frame_end, start, ovr_set, ovr_clr, ctrl_wr, run_cmp;

   trig_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .rst     (rst),
      .async_i (trig_in),
      .edge_o  (trig_edge)
   );

   assign ctrl_wr = cfg_we && (int'(cfg_addr) == ctrl_addr(NUM_CH));
   assign ovr_clr = ctrl_wr && cfg_wdata[OVR_CLR_BIT];

   // Writes only ever touch the shadow copies; actives load them at frame start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dly_sh_q  <= '0;
         wid_sh_q  <= '0;
         flen_sh_q <= '0;
         arm_q     <= 1'b0;
      end else if (cfg_we) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (int'(cfg_addr) == delay_addr(i)) dly_sh_q[i] <= cfg_wdata;
            if (int'(cfg_addr) == width_addr(i)) wid_sh_q[i] <= cfg_wdata;
         end
         if (int'(cfg_addr) == frame_addr(NUM_CH)) flen_sh_q <= cfg_wdata;
         if (ctrl_wr) arm_q <= cfg_wdata[ARM_BIT];
      end
   end

   assign last_cnt  = (flen_act_q == '0) ? '0 : flen_act_q - CNT_W'(1);
   assign frame_end = (cnt_q == last_cnt);
   assign edge_acc  = trig_edge & arm_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      case (state_q)
         IDLE: begin
            if (edge_acc) begin
               state_d = RUN;
               start   = 1'b1;
            end
         end
         RUN: begin
`ifdef RETRIGGER_EN
            if (edge_acc)       start   = 1'b1;
            else if (frame_end) state_d = IDLE;
`else
            if (frame_end)      state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // The last frame cycle and a restart cycle both emit 0 so the next cycle never shows a stale pulse.
   always_comb begin
      busy    = (state_q == RUN);
      run_cmp = (state_q == RUN) && !frame_end && !start;
`ifdef RETRIGGER_EN
      ovr_set = 1'b0;
`else
      ovr_set = (state_q == RUN) && edge_acc;
`endif
   end

   always_comb begin
      ch_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ch_d[i] = run_cmp
                 && ({1'b0, dly_act_q[i]} <= {1'b0, cnt_q})
                 && ({1'b0, cnt_q} < ({1'b0, dly_act_q[i]} + {1'b0, wid_act_q[i]}));
      end
   end

   always_comb begin
      cnt_d  = cnt_q;
      tcnt_d = tcnt_q;
      if (start) begin
         cnt_d  = '0;
         tcnt_d = tcnt_q + 16'd1;
      end else if ((state_q == RUN) && !frame_end) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      ovr_d = ovr_set ? 1'b1 : (ovr_clr ? 1'b0 : ovr_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dly_act_q  <= '0;
         wid_act_q  <= '0;
         flen_act_q <= '0;
         cnt_q      <= '0;
         tcnt_q     <= '0;
         ovr_q      <= 1'b0;
         ch_q       <= '0;
      end else begin
         cnt_q  <= cnt_d;
         tcnt_q <= tcnt_d;
         ovr_q  <= ovr_d;
         ch_q   <= ch_d;
         if (start) begin
            dly_act_q  <= dly_sh_q;
            wid_act_q  <= wid_sh_q;
            flen_act_q <= flen_sh_q;
         end
      end
   end

   assign ch_out     = ch_q;
   assign overrun    = ovr_q;
   assign trig_count = tcnt_q;

endmodule

// File: doc/trig_delay_gen.md
Name: trig_delay_gen

Overview:
- Parametrised multi-channel trigger-to-pulse sequencer.
- On each accepted trigger edge from the external function generator, it runs one timing frame. In that frame every channel emits one high pulse with programmable delay and width.
- A configuration port programs the timing, so no RTL edit is needed to change it. Shadow registers make mid-frame reprogramming glitch-free.
- Sits between the trigger input pad and the PA/US/pulser drive outputs.

Parameters:
- NUM_CH, 4, number of independent pulse channels (1..16).
- CNT_W, 16, width of frame counter and of delay/width/frame-length registers.
- SYNC_STAGES, 2, flops in the trigger synchroniser (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- trig_in  in  1  external trigger, asynchronous to clk.
- cfg_we  in  1  config write strobe, one write per cycle.
- cfg_addr  in  $clog2(2*NUM_CH+2)  config register address.
- cfg_wdata  in  CNT_W  config write data.
- ch_out  out  NUM_CH  registered channel pulses.
- busy  out  1  high while a frame runs.
- overrun  out  1  sticky: trigger edge arrived while busy.
- trig_count  out  16  accepted-trigger count, wraps 0xFFFF->0.

Behaviour:
- Reset (async assert, sync release). All shadow/active registers = 0, arm = 0, state IDLE, counter = 0, ch_out = 0, busy = 0, overrun = 0, trig_count = 0.
- Register map:
  - addr 2i = delay_i.
  - addr 2i+1 = width_i.
  - addr 2*NUM_CH = frame_len.
  - addr 2*NUM_CH+1 = control: bit0 arm, bit1 clear overrun (self-clearing, not stored).
  - Writes to unmapped addresses are ignored.
- All config writes land in shadow registers only.
- Trigger path:
  - trig_in passes through SYNC_STAGES flops, then rising-edge detect.
  - Edge visible in cycle A = SYNC_STAGES+1 cycles after the trig_in rising edge.
- State machine: IDLE, RUN.
  - IDLE -> RUN on edge in cycle A when arm = 1.
  - In that transition: active regs <= shadows, counter <= 0, trig_count += 1, busy = 1 from cycle A+1.
  - An edge with arm = 0 is ignored; no count, no overrun.
  - RUN: counter increments each cycle. Frame cycle k = counter value k.
  - RUN -> IDLE when counter == max(frame_len,1)-1. Then busy = 0 and the counter holds.
- Channel output:
  - ch_out[i] is registered from (CNT_W+1)-bit comparisons delay_i <= counter < delay_i+width_i, evaluated in RUN only. No wrap on delay+width.
  - So ch_out[i] is high for frame cycles delay_i+1 .. delay_i+width_i.
  - width_i = 0 gives no pulse.
  - Pulses extending past the frame end are truncated: ch_out is forced 0 the cycle after leaving RUN.
- Retrigger: an edge in RUN does not restart the frame and sets overrun (without RETRIGGER_EN).
- Simultaneous events:
  - Config write in cycle A: active regs load pre-write shadow values; the write applies to the next frame.
  - overrun set and clear in the same cycle: set wins.
  - Arm cleared during RUN: the current frame completes.
- Reset mid-frame: outputs drop immediately (async); IDLE.

Optional Feature:
- Macro: RETRIGGER_EN.
- Defined: an accepted edge in RUN (arm = 1) restarts the frame in the same way as from IDLE:
  - reload actives, counter <= 0, trig_count += 1;
  - ch_out computed fresh from counter 0;
  - overrun is never set.
- Undefined: retrigger in RUN is ignored and sets overrun, as above.

Decomposition:
- Package trig_delay_pkg:
  - state enum {IDLE, RUN};
  - address constant functions (delay/width/frame/control offsets);
  - control bit positions ARM_BIT = 0, OVR_CLR_BIT = 1.
- Sub-module trig_sync_edge (params SYNC_STAGES): synchroniser chain plus registered rising-edge pulse output. Reused by any future external-trigger block.

Test Plan:
- NUM_CH=4, clk 1 MHz. Write delay0=10, width0=10, delay1=33, width1=10, frame_len=50, arm. One trig_in pulse -> ch_out[0] high frame cycles 11..20, ch_out[1] high 34..43, busy high 50 cycles, trig_count=1.
- Trigger with arm=0 -> no busy, ch_out stays 0, trig_count stays 0.
- Second trigger at frame cycle 25:
  - RETRIGGER_EN off: frame unchanged, overrun=1. Control write bit1 -> overrun=0.
  - RETRIGGER_EN on: counter restarts, ch_out[0] pulses again 11..20 after the restart, trig_count=2.
- Mid-frame write delay0=5 at cycle 15 -> current frame unchanged. Next frame ch_out[0] high cycles 6..15.
- Edge cases:
  - delay2=45, width2=20, frame_len=50: ch_out[2] high cycles 46..49, then low.
  - width3=0: no pulse.
  - delay=0xFFFF, width=2: no overflow false-high.
- Assert rst at frame cycle 12 while ch_out[0]=1 -> all outputs 0 immediately, busy=0, trig_count=0. After release, the next trigger is ignored until re-armed.
